// File: rtl/aes_pkg.sv
// Shared AES byte/block definitions and ShiftRows index tables.
// Byte order inside a block is i = 4*col + row.
package aes_pkg;

  localparam int BYTE_W      = 8;
  localparam int BLOCK_BYTES = 16;

  typedef logic [0:BYTE_W-1] byte_t;
  typedef logic [3:0]        idx_t;

  // Inverse ShiftRows: output byte i is taken from input byte INV_SR_IDX[i].
  // Element 15 is the leftmost entry.
  localparam logic [15:0][3:0] INV_SR_IDX = {
    4'd3,  4'd6,  4'd9,  4'd12,
    4'd15, 4'd2,  4'd5,  4'd8,
    4'd11, 4'd14, 4'd1,  4'd4,
    4'd7,  4'd10, 4'd13, 4'd0
  };

  // Forward ShiftRows: output byte i is taken from input byte FWD_SR_IDX[i].
  localparam logic [15:0][3:0] FWD_SR_IDX = {
    4'd11, 4'd6,  4'd1,  4'd12,
    4'd7,  4'd2,  4'd13, 4'd8,
    4'd3,  4'd14, 4'd9,  4'd4,
    4'd15, 4'd10, 4'd5,  4'd0
  };

  function automatic idx_t inv_sr_idx(input idx_t i);
    return INV_SR_IDX[i];
  endfunction

  function automatic idx_t fwd_sr_idx(input idx_t i);
    return FWD_SR_IDX[i];
  endfunction

endpackage

// File: rtl/inv_shift_rows_stream_if.sv
// Byte-stream handshake bundle for the inverse ShiftRows block.
interface inv_shift_rows_stream_if;
  import aes_pkg::*;

  byte_t in_data;
  logic  in_valid;
  logic  in_ready;
  byte_t out_data;
  logic  out_valid;
  logic  out_ready;
  logic  out_first;
  logic  out_last;

  // Block side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_first, out_last
  );

  // Producer/consumer side
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_first, out_last
  );

endinterface

// File: rtl/inv_shift_rows_stream_bank.sv
// One 16-byte ping-pong bank: linear write port, inverse-ShiftRows
// permuted read mux and a full flag.
module inv_sr_bank
  import aes_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  idx_t  wr_addr,
  input  byte_t wr_data,
  input  logic  set_full,
  input  logic  clr_full,
  input  idx_t  rd_idx,
  output byte_t rd_data,
  output logic  full
);

  byte_t mem_r [BLOCK_BYTES];
  logic  full_r;

  // Byte storage, cleared on reset so no stale data survives an abort
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Full flag: set by the 16th write, cleared by the 16th read (never both)
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_r <= 1'b0;
    end else if (set_full) begin
      full_r <= 1'b1;
    end else if (clr_full) begin
      full_r <= 1'b0;
    end
  end

  // Read mux applies the inverse row rotation via the index table
  always_comb begin
    rd_data = mem_r[inv_sr_idx(rd_idx)];
    full    = full_r;
  end

endmodule

// File: rtl/inv_shift_rows_stream.sv
// Streaming inverse ShiftRows: bytes of a block are collected into one of
// two banks and read back in permuted order while the other bank fills.
module inv_shift_rows_stream
  import aes_pkg::*;
(
  input logic clk,
  input logic rst,
  inv_shift_rows_stream_if.slave bus
);

  logic  wr_sel_r;
  logic  rd_sel_r;
  idx_t  wr_cnt_r;
  idx_t  rd_cnt_r;
  logic  [1:0] full_s;
  byte_t rd_data_s [2];
  logic  wr_full_s;
  logic  rd_full_s;
  logic  in_fire_s;
  logic  out_fire_s;

  // Handshake decode; in_ready depends only on registered state
  always_comb begin
    wr_full_s  = full_s[wr_sel_r];
    rd_full_s  = full_s[rd_sel_r];
    in_fire_s  = bus.in_valid & ~wr_full_s;
    out_fire_s = rd_full_s & bus.out_ready;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    inv_sr_bank u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (in_fire_s && (wr_sel_r == 1'(b))),
      .wr_addr  (wr_cnt_r),
      .wr_data  (bus.in_data),
      .set_full (in_fire_s && (wr_sel_r == 1'(b)) && (wr_cnt_r == 4'd15)),
      .clr_full (out_fire_s && (rd_sel_r == 1'(b)) && (rd_cnt_r == 4'd15)),
      .rd_idx   (rd_cnt_r),
      .rd_data  (rd_data_s[b]),
      .full     (full_s[b])
    );
  end

  // Write pointer: byte counter and bank select advance per accepted byte
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_cnt_r <= 4'd0;
      wr_sel_r <= 1'b0;
    end else if (in_fire_s) begin
      wr_cnt_r <= wr_cnt_r + 4'd1;
      if (wr_cnt_r == 4'd15) begin
        wr_sel_r <= ~wr_sel_r;
      end
    end
  end

  // Read pointer: byte counter and bank select advance per delivered byte
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_cnt_r <= 4'd0;
      rd_sel_r <= 1'b0;
    end else if (out_fire_s) begin
      rd_cnt_r <= rd_cnt_r + 4'd1;
      if (rd_cnt_r == 4'd15) begin
        rd_sel_r <= ~rd_sel_r;
      end
    end
  end

  // Output decode; data is forced to zero whenever nothing is offered
  always_comb begin
    bus.in_ready  = ~wr_full_s;
    bus.out_valid = rd_full_s;
    bus.out_data  = rd_full_s ? rd_data_s[rd_sel_r] : '0;
    bus.out_first = rd_full_s & (rd_cnt_r == 4'd0);
    bus.out_last  = rd_full_s & (rd_cnt_r == 4'd15);
  end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Self-checking bench for inv_shift_rows_stream: scoreboard model of the
// block permutation plus directed literal sequences.
module tb_inv_shift_rows_stream;
  import aes_pkg::*;

  typedef logic [7:0] blk_t [16];
  typedef struct { logic [7:0] d; bit f; bit l; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  inv_shift_rows_stream_if bus();

  inv_shift_rows_stream dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int rdy_mode = 1;
  exp_t exp_q[$];
  logic [7:0] part_q[$];
  logic [7:0] got_q[$];
  int got_cyc[$];
  logic [7:0] src_q[$];
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [7:0] seq1 [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                            8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
  logic [7:0] seq5 [16] = '{8'h10, 8'h1D, 8'h1A, 8'h17, 8'h14, 8'h11, 8'h1E, 8'h1B,
                            8'h18, 8'h15, 8'h12, 8'h1F, 8'h1C, 8'h19, 8'h16, 8'h13};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vec_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Model: row r of column c comes from column (c - r) mod 4 of the input
  function automatic blk_t inv_perm(input blk_t blk);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[r + 4*c] = blk[r + 4*((c - r + 4) % 4)];
    return o;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready driver: 0 = held low, 1 = held high, 2 = random
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: bus.out_ready = 1'b0;
      1: bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Compare process: checks outputs every cycle and feeds the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      part_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() > 0});
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, ((exp_q.size() + 15) / 16) < 2});
      if (prev_stall) begin
        chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stall_data", {24'd0, bus.out_data}, {24'd0, prev_data});
      end
      if (bus.out_valid && exp_q.size() > 0) begin
        chk("out_data", {24'd0, bus.out_data}, {24'd0, exp_q[0].d});
        chk("out_first", {31'd0, bus.out_first}, {31'd0, exp_q[0].f});
        chk("out_last", {31'd0, bus.out_last}, {31'd0, exp_q[0].l});
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          got_q.push_back(bus.out_data);
          got_cyc.push_back(cyc);
        end
      end else if (!bus.out_valid) begin
        chk("idle_data", {24'd0, bus.out_data}, 32'd0);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (bus.in_valid && bus.in_ready) begin
        part_q.push_back(bus.in_data);
        if (part_q.size() == 16) begin
          blk_t b;
          blk_t p;
          for (int i = 0; i < 16; i++) b[i] = part_q[i];
          p = inv_perm(b);
          for (int i = 0; i < 16; i++) exp_q.push_back('{p[i], i == 0, i == 15});
          part_q.delete();
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int limit, output bit ok);
    bit acc;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < limit && !ok; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) ok = 1'b1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_must(input logic [7:0] b);
    bit ok;
    send_byte(b, 400, ok);
    chk("accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 2000 && exp_q.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    blk_t lin;
    blk_t pm;
    int n_acc;
    int c0;
    bit ok;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_first", {31'd0, bus.out_first}, 32'd0);
    chk("rst_out_last", {31'd0, bus.out_last}, 32'd0);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    @(posedge clk);
    #1;

    // Pin the model against the hand-computed sequence
    for (int i = 0; i < 16; i++) lin[i] = 8'(i);
    pm = inv_perm(lin);
    for (int i = 0; i < 16; i++) chk("model_pin", {24'd0, pm[i]}, {24'd0, seq1[i]});

    // Single block 0x00..0x0F, latency of one cycle
    got_q.delete();
    for (int i = 0; i < 16; i++) send_must(8'(i));
    chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lat_first", {31'd0, bus.out_first}, 32'd1);
    chk("lat_data", {24'd0, bus.out_data}, 32'd0);
    wait_drain();
    chk("seq1_count", got_q.size(), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      chk("seq1_data", {24'd0, got_q[i]}, {24'd0, seq1[i]});

    // Four back-to-back blocks at full rate
    got_q.delete();
    got_cyc.delete();
    c0 = cyc;
    for (int i = 0; i < 64; i++) send_must(8'($urandom));
    chk("in_rate", cyc - c0, 32'd64);
    wait_drain();
    chk("b2b_count", got_q.size(), 32'd64);
    if (got_cyc.size() == 64) chk("out_rate", got_cyc[63] - got_cyc[0], 32'd63);

    // Both banks fill with out_ready low
    rdy_mode = 0;
    @(posedge clk);
    #1;
    got_q.delete();
    n_acc = 0;
    ok = 1'b1;
    while (n_acc < 40 && ok) begin
      send_byte(8'(8'h40 + n_acc), 4, ok);
      if (ok) n_acc++;
    end
    chk("stall_accepted", n_acc, 32'd32);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    for (int i = n_acc; i < 40; i++) send_must(8'(8'h40 + i));
    wait_drain();
    chk("stall_out_count", got_q.size(), 32'd32);
    for (int i = 40; i < 48; i++) send_must(8'(8'h40 + i));
    wait_drain();
    chk("stall_total_count", got_q.size(), 32'd48);

    // Random out_ready stalls over 100 blocks
    rdy_mode = 2;
    got_q.delete();
    for (int i = 0; i < 1600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_must(8'($urandom));
    end
    rdy_mode = 1;
    wait_drain();
    chk("rand_count", got_q.size(), 32'd1600);

    // Reset mid-block, then a fresh block
    do_reset();
    for (int i = 0; i < 7; i++) send_must(8'(8'hA0 + i));
    do_reset();
    got_q.delete();
    for (int i = 0; i < 16; i++) send_must(8'(8'h10 + i));
    wait_drain();
    chk("seq5_count", got_q.size(), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      chk("seq5_data", {24'd0, got_q[i]}, {24'd0, seq5[i]});

    // Forward ShiftRows of the output recovers the input (50 blocks)
    rdy_mode = 2;
    got_q.delete();
    src_q.delete();
    for (int i = 0; i < 800; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      src_q.push_back(v);
      send_must(v);
    end
    rdy_mode = 1;
    wait_drain();
    chk("fwd_count", got_q.size(), 32'd800);
    if (got_q.size() == 800) begin
      for (int b = 0; b < 50; b++)
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            chk("fwd_recover", {24'd0, got_q[16*b + r + 4*((c + r) % 4)]},
                {24'd0, src_q[16*b + r + 4*c]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
